// File: rtl/sdf_pkg.sv
// Shared types for the SDF FFT front-end sequencer: FSM states, the per-slot tag
// carried alongside the pipeline latency, and the frame-index width helper.
package sdf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    typedef struct packed {
        logic is_real;
        logic first;
    } tag_t;

    function automatic int logn(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/tag_delay.sv
// Fixed-latency shift register for slot tags, so that out_valid/out_first line up
// with the FFT output of the sample they were issued with.
module tag_delay
    import sdf_pkg::*;
#(
    parameter int DEPTH = 68
) (
    input  logic clk,
    input  logic rst,
    input  tag_t d,
    output tag_t q
);

    tag_t stages [DEPTH];

    // NOTE: every stage is cleared on reset so an aborted frame can never surface as out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/sdf_stream_ctrl.sv
// Turns a valid/ready sample stream into gap-free N-sample frames for sdf4, with
// zero padding, N-sample flush, and latency-aligned out_valid/out_first tags.
// Optional SDF_CTRL_STATS_EN adds frame_count and underrun_count outputs.
module sdf_stream_ctrl
    import sdf_pkg::*;
#(
    parameter int N     = 64,
    parameter int WIDTH = 8,
    parameter int LAT   = 68,
    localparam int LOGN = logn(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    input  logic             clr_err,
    output logic             sdf_enable,
    output logic [WIDTH-1:0] sdf_re,
    output logic [WIDTH-1:0] sdf_im,
    output logic [LOGN-1:0]  smp_idx,
    output logic             out_valid,
    output logic             out_first,
    output logic             busy,
    output logic             underrun
`ifdef SDF_CTRL_STATS_EN
    ,
    output logic [15:0]      frame_count,
    output logic [15:0]      underrun_count
`endif
);

    localparam int CW = $clog2(LAT + 2);
    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

    state_t        state;
    tag_t          tag_q;
    tag_t          tag_out;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_next;
    logic          accept;
    logic          last_slot;
    logic          gap_pad;

    // in_ready is forced low while rst is held, not just after the first edge.
    assign in_ready  = !rst && (state == IDLE || state == RUN);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_slot = (smp_idx == LAST_IDX);
    assign gap_pad   = (state == RUN) && !in_valid && !last_slot;

    assign inflight_next = inflight + CW'(accept) - CW'(tag_out.is_real);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sdf_enable <= 1'b0;
            sdf_re     <= '0;
            sdf_im     <= '0;
            smp_idx    <= '0;
            tag_q      <= '0;
            underrun   <= 1'b0;
            inflight   <= '0;
        end else begin
            inflight <= inflight_next;
            underrun <= gap_pad || (underrun && !clr_err);
            case (state)
                IDLE: begin
                    smp_idx <= '0;
                    if (accept) begin
                        state      <= RUN;
                        sdf_enable <= 1'b1;
                        sdf_re     <= in_re;
                        sdf_im     <= in_im;
                        tag_q      <= '{is_real: 1'b1, first: 1'b1};
                    end else begin
                        sdf_enable <= 1'b0;
                        sdf_re     <= '0;
                        sdf_im     <= '0;
                        tag_q      <= '0;
                    end
                end
                RUN: begin
                    // A missing sample on the last slot ends the stream instead of padding.
                    smp_idx <= smp_idx + 1'b1;
                    sdf_re  <= in_valid ? in_re : '0;
                    sdf_im  <= in_valid ? in_im : '0;
                    tag_q   <= '{is_real: in_valid, first: in_valid && last_slot};
                    if (!in_valid && last_slot) state <= FLUSH;
                end
                FLUSH: begin
                    sdf_re <= '0;
                    sdf_im <= '0;
                    tag_q  <= '0;
                    if (last_slot) begin
                        state      <= DRAIN;
                        sdf_enable <= 1'b0;
                        smp_idx    <= '0;
                    end else begin
                        smp_idx <= smp_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (inflight_next == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    tag_delay #(.DEPTH(LAT)) u_tag_delay (
        .clk (clk),
        .rst (rst),
        .d   (tag_q),
        .q   (tag_out)
    );

    assign out_valid = tag_out.is_real;
    assign out_first = tag_out.first;

`ifdef SDF_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count    <= '0;
            underrun_count <= '0;
        end else begin
            if (tag_out.first) frame_count <= frame_count + 16'd1;
            if (gap_pad && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdf_stream_ctrl.sv
// Bench for sdf_stream_ctrl (N=8, LAT=5): a per-cycle schedule is derived from the
// frame/pad layout of each directed run and compared against the DUT every cycle.
module tb_sdf_stream_ctrl;

    localparam int N     = 8;
    localparam int WIDTH = 8;
    localparam int LAT   = 5;
    localparam int WIN   = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] in_re = '0;
    logic [WIDTH-1:0] in_im = '0;
    logic             in_ready;
    logic             sdf_enable;
    logic [WIDTH-1:0] sdf_re;
    logic [WIDTH-1:0] sdf_im;
    logic [2:0]       smp_idx;
    logic             out_valid;
    logic             out_first;
    logic             busy;
    logic             underrun;
`ifdef SDF_CTRL_STATS_EN
    logic [15:0]      frame_count;
    logic [15:0]      underrun_count;
`endif

    sdf_stream_ctrl #(.N(N), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .clr_err    (clr_err),
        .sdf_enable (sdf_enable),
        .sdf_re     (sdf_re),
        .sdf_im     (sdf_im),
        .smp_idx    (smp_idx),
        .out_valid  (out_valid),
        .out_first  (out_first),
        .busy       (busy),
        .underrun   (underrun)
`ifdef SDF_CTRL_STATS_EN
        ,
        .frame_count    (frame_count),
        .underrun_count (underrun_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;
    bit chk_en = 1'b0;
    int idle_at;

    // Expected per-cycle outputs and per-cycle stimulus of the current run.
    logic       exp_en [WIN];
    logic       exp_ov [WIN];
    logic       exp_of [WIN];
    logic       exp_busy [WIN];
    logic       exp_rdy [WIN];
    logic       exp_ur [WIN];
    logic [7:0] exp_re [WIN];
    logic [7:0] exp_im [WIN];
    logic [2:0] exp_idx [WIN];
    logic       drv_v [WIN];
    logic       drv_clr [WIN];
    logic [7:0] drv_re [WIN];
    logic [7:0] drv_im [WIN];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_plan();
        for (int c = 0; c < WIN; c++) begin
            exp_en[c] = 0; exp_ov[c] = 0; exp_of[c] = 0; exp_busy[c] = 0;
            exp_rdy[c] = 1; exp_ur[c] = 0; exp_re[c] = 0; exp_im[c] = 0;
            exp_idx[c] = 0; drv_v[c] = 0; drv_clr[c] = 0; drv_re[c] = 0; drv_im[c] = 0;
        end
        idle_at = 0;
    endtask

    // Stream of s slots (s a multiple of N) starting with a handshake in cycle 0;
    // slot k carries value k+1 unless pad[k]. Slot k appears on sdf_* in cycle k+1.
    task automatic build(input int s, input logic [63:0] pad, input int clr_c, input bit hold);
        int last_real;
        clear_plan();
        last_real = -1;
        for (int k = 0; k < s; k++) begin
            exp_en[k+1]  = 1;
            exp_idx[k+1] = 3'(k % N);
            if (!pad[k]) begin
                drv_v[k]  = 1;
                drv_re[k] = 8'(k + 1);
                drv_im[k] = 8'(k + 1) ^ 8'hA5;
                exp_re[k+1] = drv_re[k];
                exp_im[k+1] = drv_im[k];
                exp_ov[k+1+LAT] = 1;
                exp_of[k+1+LAT] = (k % N == 0);
                last_real = k;
            end
        end
        for (int j = 0; j < N; j++) begin
            exp_en[s+1+j]  = 1;
            exp_idx[s+1+j] = 3'(j);
        end
        idle_at = (s + N + 2 > last_real + LAT + 2) ? s + N + 2 : last_real + LAT + 2;
        for (int c = 1; c < idle_at; c++) exp_busy[c] = 1;
        for (int c = s + 1; c < idle_at; c++) begin
            exp_rdy[c] = 0;
            if (hold) begin
                drv_v[c] = 1; drv_re[c] = 8'h77; drv_im[c] = 8'h77;
            end
        end
        if (clr_c >= 0) drv_clr[clr_c] = 1;
        for (int c = 0; c < WIN - 1; c++)
            exp_ur[c+1] = (c >= 1 && c < s && pad[c]) || (exp_ur[c] && !drv_clr[c]);
    endtask

    task automatic run_plan(input int len);
        @(posedge clk); #1;
        base   = cyc;
        chk_en = 1'b1;
        for (int c = 0; c < len; c++) begin
            in_valid = drv_v[c];
            in_re    = drv_re[c];
            in_im    = drv_im[c];
            clr_err  = drv_clr[c];
            @(posedge clk); #1;
        end
        chk_en   = 1'b0;
        in_valid = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic clear_underrun();
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        check("underrun_after_clr", 32'(underrun), 32'd0);
    endtask

    always @(negedge clk) begin
        int r;
        if (chk_en) begin
            r = cyc - base;
            if (r < WIN) begin
                check($sformatf("sdf_enable@%0d", r), 32'(sdf_enable), 32'(exp_en[r]));
                check($sformatf("sdf_re@%0d", r),     32'(sdf_re),     32'(exp_re[r]));
                check($sformatf("sdf_im@%0d", r),     32'(sdf_im),     32'(exp_im[r]));
                check($sformatf("smp_idx@%0d", r),    32'(smp_idx),    32'(exp_idx[r]));
                check($sformatf("out_valid@%0d", r),  32'(out_valid),  32'(exp_ov[r]));
                check($sformatf("out_first@%0d", r),  32'(out_first),  32'(exp_of[r]));
                check($sformatf("busy@%0d", r),       32'(busy),       32'(exp_busy[r]));
                check($sformatf("in_ready@%0d", r),   32'(in_ready),   32'(exp_rdy[r]));
                check($sformatf("underrun@%0d", r),   32'(underrun),   32'(exp_ur[r]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_ov, n_ov, n_en, n_of;

        #1;
        check("rst_in_ready",   32'(in_ready),   32'd0);
        check("rst_sdf_enable", 32'(sdf_enable), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Single frame; pin the model with hand-computed figures first.
        build(8, 64'h0, -1, 1'b0);
        first_ov = -1; n_ov = 0; n_en = 0;
        for (int c = 0; c < WIN; c++) begin
            if (exp_ov[c] && first_ov < 0) first_ov = c;
            n_ov += int'(exp_ov[c]);
            n_en += int'(exp_en[c]);
        end
        check("pin_ov_start", 32'(first_ov), 32'd6);
        check("pin_ov_len",   32'(n_ov),     32'd8);
        check("pin_en_len",   32'(n_en),     32'd16);
        check("pin_idle_at",  32'(idle_at),  32'd18);
        run_plan(idle_at + 3);

        // Back-to-back three frames.
        build(24, 64'h0, -1, 1'b0);
        n_ov = 0; n_of = 0;
        for (int c = 0; c < WIN; c++) begin
            n_ov += int'(exp_ov[c]);
            n_of += int'(exp_of[c]);
        end
        check("pin_b2b_ov_len", 32'(n_ov), 32'd24);
        check("pin_b2b_first",  32'(n_of), 32'd3);
        check("pin_b2b_of14",   32'(exp_of[14]), 32'd1);
        run_plan(idle_at + 3);
`ifdef SDF_CTRL_STATS_EN
        check("frame_count_4", 32'(frame_count), 32'd4);
`endif

        // Mid-frame gap at slot 3, cleared later by clr_err.
        build(8, 64'h8, 6, 1'b0);
        check("pin_gap_ov_hole", 32'(exp_ov[9]), 32'd0);
        run_plan(idle_at + 3);
`ifdef SDF_CTRL_STATS_EN
        check("underrun_count_1", 32'(underrun_count), 32'd1);
`endif

        // clr_err coincides with a second underrun: the set must win.
        build(16, 64'h408, 10, 1'b0);
        check("pin_simul_ur11", 32'(exp_ur[11]), 32'd1);
        run_plan(idle_at + 3);
        clear_underrun();

        // Frame-boundary end with in_valid held through FLUSH/DRAIN: nothing accepted.
        build(8, 64'h0, -1, 1'b1);
        run_plan(idle_at);
        check("underrun_boundary", 32'(underrun), 32'd0);

        // Reset asserted while smp_idx = 4.
        build(8, 64'h0, -1, 1'b0);
        run_plan(5);
        in_valid = 1'b1;
        check("idx_before_rst", 32'(smp_idx), 32'd4);
        rst = 1'b1;
        #1;
        check("arst_sdf_enable", 32'(sdf_enable), 32'd0);
        check("arst_sdf_re",     32'(sdf_re),     32'd0);
        check("arst_smp_idx",    32'(smp_idx),    32'd0);
        check("arst_busy",       32'(busy),       32'd0);
        check("arst_in_ready",   32'(in_ready),   32'd0);
        check("arst_out_valid",  32'(out_valid),  32'd0);
        @(posedge clk); @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b0;
        clear_plan();
        run_plan(LAT + N + 2);

        // Next frame after reset behaves as a clean single frame.
        build(8, 64'h0, -1, 1'b0);
        run_plan(idle_at + 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
